// File: rtl/nvme_ctrl_responder.sv
// rtl/nvme_ctrl_responder.sv - NVMe-style SQ fetch / CQ post responder with AXI-Lite doorbells
module nvme_ctrl_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    OUTSTANDING = 16,
    parameter logic [ADDR_WIDTH-1:0] SQ_BASE     = 32'h0002_0000,
    parameter logic [ADDR_WIDTH-1:0] CQ_BASE     = 32'h0002_0400
) (
    input  logic                  clk,
    input  logic                  rst,

    // doorbell slave (write-only AXI-Lite)
    input  logic [31:0]           db_awaddr,
    input  logic                  db_awvalid,
    output logic                  db_awready,
    input  logic [31:0]           db_wdata,
    input  logic [3:0]            db_wstrb,
    input  logic                  db_wvalid,
    output logic                  db_wready,
    output logic [1:0]            db_bresp,
    output logic                  db_bvalid,
    input  logic                  db_bready,

    // SQ entry fetch (AXI4 read master)
    output logic [ADDR_WIDTH-1:0] sq_araddr,
    output logic [7:0]            sq_arlen,
    output logic [2:0]            sq_arsize,
    output logic [1:0]            sq_arburst,
    output logic                  sq_arvalid,
    input  logic                  sq_arready,
    input  logic [511:0]          sq_rdata,
    input  logic [1:0]            sq_rresp,
    input  logic                  sq_rlast,
    input  logic                  sq_rvalid,
    output logic                  sq_rready,

    // CQ entry post (AXI4 write master)
    output logic [ADDR_WIDTH-1:0] cq_awaddr,
    output logic [7:0]            cq_awlen,
    output logic [2:0]            cq_awsize,
    output logic [1:0]            cq_awburst,
    output logic                  cq_awvalid,
    input  logic                  cq_awready,
    output logic [127:0]          cq_wdata,
    output logic [15:0]           cq_wstrb,
    output logic                  cq_wlast,
    output logic                  cq_wvalid,
    input  logic                  cq_wready,
    input  logic [1:0]            cq_bresp,
    input  logic                  cq_bvalid,
    output logic                  cq_bready
);

    localparam int PTR_W = $clog2(OUTSTANDING);

    localparam logic [11:0] SQ1TDBL_OFS = 12'd1008;
    localparam logic [11:0] CQ1HDBL_OFS = 12'd1012;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_AR,
        S_FETCH_R,
        S_POST,
        S_POST_B
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [PTR_W-1:0]   r_sq_tail;
    logic [PTR_W-1:0]   r_sq_head;
    logic [PTR_W-1:0]   r_cq_tail;
    logic [PTR_W-1:0]   r_cq_head;
    logic               r_cq_phase;
    logic [15:0]        r_cid;
    logic [14:0]        r_status;

    logic               r_db_bvalid;
    logic               r_aw_done;
    logic               r_w_done;

    logic               w_db_accept;
    logic               w_sq_pending;
    logic               w_cq_full;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_post_done;
    logic               w_unused;

    // Address and data are taken together and only while no response is outstanding.
    assign w_db_accept = db_awvalid & db_wvalid & ~r_db_bvalid & ~rst;
    assign db_awready  = w_db_accept;
    assign db_wready   = w_db_accept;
    assign db_bvalid   = r_db_bvalid;
    assign db_bresp    = 2'b00;

    // Work is pending when the SQ is non-empty; the CQ keeps one slot free to tell full from empty.
    assign w_sq_pending = (r_sq_head != r_sq_tail);
    assign w_cq_full    = ((r_cq_tail + PTR_W'(1)) == r_cq_head);

    assign w_aw_hs     = cq_awvalid & cq_awready;
    assign w_w_hs      = cq_wvalid & cq_wready;
    assign w_post_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    // Fixed single-beat burst attributes: 64-byte SQ entries, 16-byte CQ entries.
    assign sq_araddr  = SQ_BASE + (ADDR_WIDTH'(r_sq_head) << 6);
    assign sq_arlen   = 8'd0;
    assign sq_arsize  = 3'd6;
    assign sq_arburst = 2'b01;

    assign cq_awaddr  = CQ_BASE + (ADDR_WIDTH'(r_cq_tail) << 4);
    assign cq_awlen   = 8'd0;
    assign cq_awsize  = 3'd4;
    assign cq_awburst = 2'b01;
    assign cq_wstrb   = '1;
    assign cq_wlast   = 1'b1;

    // Completion entry: status | phase | cid | sqid=1 | sq_head | reserved dwords.
    assign cq_wdata = {r_status, r_cq_phase, r_cid, 16'd1, 16'(r_sq_head), 64'd0};

    // Fields of the bus that this responder has no use for.
    assign w_unused = ^{db_awaddr[31:12], db_wstrb, db_wdata[31:PTR_W],
                        sq_rdata[511:32], sq_rdata[15:0], sq_rlast, cq_bresp};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and channel valid/ready outputs.
    always_comb begin
        w_next     = r_state;
        sq_arvalid = 1'b0;
        sq_rready  = 1'b0;
        cq_awvalid = 1'b0;
        cq_wvalid  = 1'b0;
        cq_bready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sq_pending && !w_cq_full) begin
                    w_next = S_FETCH_AR;
                end
            end
            S_FETCH_AR: begin
                sq_arvalid = 1'b1;
                if (sq_arready) begin
                    w_next = S_FETCH_R;
                end
            end
            S_FETCH_R: begin
                sq_rready = 1'b1;
                if (sq_rvalid) begin
                    w_next = S_POST;
                end
            end
            S_POST: begin
                cq_awvalid = ~r_aw_done;
                cq_wvalid  = ~r_w_done;
                if (w_post_done) begin
                    w_next = S_POST_B;
                end
            end
            S_POST_B: begin
                cq_bready = 1'b1;
                if (cq_bvalid) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Doorbell write response and register decode; unknown offsets complete with no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_bvalid <= 1'b0;
            r_sq_tail   <= '0;
            r_cq_head   <= '0;
        end else begin
            if (w_db_accept) begin
                r_db_bvalid <= 1'b1;
                if (db_awaddr[11:0] == SQ1TDBL_OFS) begin
                    r_sq_tail <= db_wdata[PTR_W-1:0];
                end else if (db_awaddr[11:0] == CQ1HDBL_OFS) begin
                    r_cq_head <= db_wdata[PTR_W-1:0];
                end
            end else if (db_bready) begin
                r_db_bvalid <= 1'b0;
            end
        end
    end

    // Per-channel handshake flags so AW and W can complete in either order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state != S_POST) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // Capture the fetched command and advance the SQ head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq_head <= '0;
            r_cid     <= '0;
            r_status  <= '0;
        end else if (r_state == S_FETCH_R && sq_rvalid) begin
            r_cid     <= sq_rdata[31:16];
            r_status  <= (sq_rresp != 2'b00) ? 15'h0006 : 15'h0000;
            r_sq_head <= r_sq_head + PTR_W'(1);
        end
    end

    // Advance the CQ tail on write response; the phase flips each time the tail wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cq_tail  <= '0;
            r_cq_phase <= 1'b1;
        end else if (r_state == S_POST_B && cq_bvalid) begin
            r_cq_tail <= r_cq_tail + PTR_W'(1);
            if (r_cq_tail == PTR_W'(OUTSTANDING - 1)) begin
                r_cq_phase <= ~r_cq_phase;
            end
        end
    end

endmodule

// File: tb/tb_nvme_ctrl_responder.sv
// tb/tb_nvme_ctrl_responder.sv - scoreboard bench for nvme_ctrl_responder
module tb_nvme_ctrl_responder;

    localparam logic [31:0] SQ_BASE = 32'h0002_0000;
    localparam logic [31:0] CQ_BASE = 32'h0002_0400;

    logic         clk;
    logic         rst;
    logic [31:0]  db_awaddr;
    logic         db_awvalid;
    logic         db_awready;
    logic [31:0]  db_wdata;
    logic [3:0]   db_wstrb;
    logic         db_wvalid;
    logic         db_wready;
    logic [1:0]   db_bresp;
    logic         db_bvalid;
    logic         db_bready;
    logic [31:0]  sq_araddr;
    logic [7:0]   sq_arlen;
    logic [2:0]   sq_arsize;
    logic [1:0]   sq_arburst;
    logic         sq_arvalid;
    logic         sq_arready;
    logic [511:0] sq_rdata;
    logic [1:0]   sq_rresp;
    logic         sq_rlast;
    logic         sq_rvalid;
    logic         sq_rready;
    logic [31:0]  cq_awaddr;
    logic [7:0]   cq_awlen;
    logic [2:0]   cq_awsize;
    logic [1:0]   cq_awburst;
    logic         cq_awvalid;
    logic         cq_awready;
    logic [127:0] cq_wdata;
    logic [15:0]  cq_wstrb;
    logic         cq_wlast;
    logic         cq_wvalid;
    logic         cq_wready;
    logic [1:0]   cq_bresp;
    logic         cq_bvalid;
    logic         cq_bready;

    nvme_ctrl_responder dut (
        .clk        (clk),
        .rst        (rst),
        .db_awaddr  (db_awaddr),
        .db_awvalid (db_awvalid),
        .db_awready (db_awready),
        .db_wdata   (db_wdata),
        .db_wstrb   (db_wstrb),
        .db_wvalid  (db_wvalid),
        .db_wready  (db_wready),
        .db_bresp   (db_bresp),
        .db_bvalid  (db_bvalid),
        .db_bready  (db_bready),
        .sq_araddr  (sq_araddr),
        .sq_arlen   (sq_arlen),
        .sq_arsize  (sq_arsize),
        .sq_arburst (sq_arburst),
        .sq_arvalid (sq_arvalid),
        .sq_arready (sq_arready),
        .sq_rdata   (sq_rdata),
        .sq_rresp   (sq_rresp),
        .sq_rlast   (sq_rlast),
        .sq_rvalid  (sq_rvalid),
        .sq_rready  (sq_rready),
        .cq_awaddr  (cq_awaddr),
        .cq_awlen   (cq_awlen),
        .cq_awsize  (cq_awsize),
        .cq_awburst (cq_awburst),
        .cq_awvalid (cq_awvalid),
        .cq_awready (cq_awready),
        .cq_wdata   (cq_wdata),
        .cq_wstrb   (cq_wstrb),
        .cq_wlast   (cq_wlast),
        .cq_wvalid  (cq_wvalid),
        .cq_wready  (cq_wready),
        .cq_bresp   (cq_bresp),
        .cq_bvalid  (cq_bvalid),
        .cq_bready  (cq_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard queues and host-side model
    logic [17:0]  sq_entries[$];
    logic [31:0]  exp_ar[$];
    logic [31:0]  exp_cq_addr[$];
    logic [127:0] exp_cq_data[$];
    logic [31:0]  got_cq_addr[$];
    logic [127:0] got_cq_data[$];

    logic [3:0]   m_sq_head;
    logic [3:0]   m_sq_tail;
    logic [3:0]   m_cq_tail;
    logic         m_phase;

    int           aw_delay = 0;
    int           w_delay  = 0;
    int           aw_wait  = 0;
    int           w_wait   = 0;
    bit           aw_seen  = 0;
    bit           saw_ar   = 0;
    int           bp_hits  = 0;
    int           n_posts  = 0;
    logic [31:0]  last_cq_addr = '0;
    logic         last_phase   = 1'b0;

    task automatic reset_model();
        sq_entries.delete();
        exp_ar.delete();
        exp_cq_addr.delete();
        exp_cq_data.delete();
        got_cq_addr.delete();
        got_cq_data.delete();
        m_sq_head = '0;
        m_sq_tail = '0;
        m_cq_tail = '0;
        m_phase   = 1'b1;
    endtask

    // Memory-side responder and monitor: inputs updated on the falling edge.
    initial begin
        logic [17:0]  e;
        logic [31:0]  a;
        logic [127:0] d;
        logic [127:0] ed;
        sq_arready = 1'b1;
        sq_rvalid  = 1'b0;
        sq_rdata   = '0;
        sq_rresp   = 2'b00;
        sq_rlast   = 1'b1;
        cq_awready = 1'b0;
        cq_wready  = 1'b0;
        cq_bvalid  = 1'b0;
        cq_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                sq_rvalid  = 1'b0;
                cq_awready = 1'b0;
                cq_wready  = 1'b0;
                cq_bvalid  = 1'b0;
                aw_wait    = 0;
                w_wait     = 0;
                aw_seen    = 0;
            end else begin
                if (sq_arvalid) begin
                    saw_ar = 1;
                    check_eq("sq_ar_attr", {sq_arlen, sq_arsize, sq_arburst}, {8'd0, 3'd6, 2'd1});
                    if (exp_ar.size() > 0) check_eq("sq_araddr", sq_araddr, exp_ar.pop_front());
                    else check_eq("sq_ar_expected", exp_ar.size(), 1);
                end
                sq_rvalid = 1'b0;
                if (sq_rready && sq_entries.size() > 0) begin
                    e = sq_entries.pop_front();
                    for (int k = 0; k < 16; k++) sq_rdata[k*32 +: 32] = $urandom();
                    sq_rdata[31:16] = e[15:0];
                    sq_rresp  = e[17:16];
                    sq_rvalid = 1'b1;
                end
                if (cq_awvalid) begin
                    cq_awready = (aw_wait >= aw_delay);
                    aw_wait++;
                end else begin
                    cq_awready = 1'b0;
                    aw_wait    = 0;
                end
                if (cq_wvalid) begin
                    cq_wready = (w_wait >= w_delay);
                    w_wait++;
                end else begin
                    cq_wready = 1'b0;
                    w_wait    = 0;
                end
                if (aw_seen && cq_wvalid) begin
                    bp_hits++;
                    check_eq("bp_awvalid_low", cq_awvalid, 1'b0);
                end
                if (cq_awvalid && cq_awready) begin
                    check_eq("cq_aw_attr", {cq_awlen, cq_awsize, cq_awburst}, {8'd0, 3'd4, 2'd1});
                    got_cq_addr.push_back(cq_awaddr);
                    aw_seen = 1;
                end
                if (cq_wvalid && cq_wready) begin
                    check_eq("cq_w_attr", {cq_wstrb, cq_wlast}, {16'hffff, 1'b1});
                    got_cq_data.push_back(cq_wdata);
                    aw_seen = 0;
                end
                while (got_cq_addr.size() > 0 && got_cq_data.size() > 0) begin
                    a = got_cq_addr.pop_front();
                    d = got_cq_data.pop_front();
                    n_posts++;
                    last_cq_addr = a;
                    last_phase   = d[112];
                    if (exp_cq_data.size() > 0) begin
                        ed = exp_cq_data.pop_front();
                        check_eq("cq_awaddr", a, exp_cq_addr.pop_front());
                        check_eq("cq_wdata", d, ed);
                    end else begin
                        check_eq("cq_expected", exp_cq_data.size(), 1);
                    end
                end
                cq_bvalid = cq_bready;
            end
        end
    end

    task automatic db_write(input logic [11:0] off, input logic [31:0] data);
        @(negedge clk);
        db_awaddr  = {20'h0, off};
        db_wdata   = data;
        db_wstrb   = 4'hf;
        db_awvalid = 1'b1;
        db_wvalid  = 1'b1;
        db_bready  = 1'b0;
        #1;
        check_eq("db_ready", {db_awready, db_wready}, 2'b11);
        @(negedge clk);
        db_awvalid = 1'b0;
        db_wvalid  = 1'b0;
        check_eq("db_bvalid", db_bvalid, 1'b1);
        check_eq("db_bresp", db_bresp, 2'b00);
        db_bready = 1'b1;
        @(negedge clk);
        db_bready = 1'b0;
        check_eq("db_bvalid_clr", db_bvalid, 1'b0);
    endtask

    // Queue one SQ entry, push its expected fetch and completion, ring the SQ tail doorbell.
    task automatic submit(input logic [15:0] cid, input logic [1:0] resp);
        logic [127:0] d;
        sq_entries.push_back({resp, cid});
        exp_ar.push_back(SQ_BASE + {22'd0, m_sq_head, 6'd0});
        m_sq_head = m_sq_head + 4'd1;
        d = '0;
        d[79:64]   = {12'd0, m_sq_head};
        d[95:80]   = 16'd1;
        d[111:96]  = cid;
        d[112]     = m_phase;
        d[127:113] = (resp != 2'b00) ? 15'd6 : 15'd0;
        exp_cq_addr.push_back(CQ_BASE + {24'd0, m_cq_tail, 4'd0});
        exp_cq_data.push_back(d);
        if (m_cq_tail == 4'd15) m_phase = ~m_phase;
        m_cq_tail = m_cq_tail + 4'd1;
        m_sq_tail = m_sq_tail + 4'd1;
        db_write(12'd1008, {28'd0, m_sq_tail});
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_cq_data.size() > 0 || sq_arvalid || sq_rready || cq_awvalid ||
                cq_wvalid || cq_bready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq(tag, exp_cq_data.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        reset_model();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;
        rst        = 1'b1;
        db_awaddr  = '0;
        db_awvalid = 1'b0;
        db_wdata   = '0;
        db_wstrb   = '0;
        db_wvalid  = 1'b0;
        db_bready  = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check_eq("rst_outputs",
                 {sq_arvalid, sq_rready, cq_awvalid, cq_wvalid, cq_bready, db_bvalid, db_awready},
                 7'b0);
        rst = 1'b0;

        // single command
        submit(16'h0000, 2'b00);
        wait_done("single_done");
        check_eq("single_addr", last_cq_addr, 32'h0002_0400);
        check_eq("single_phase", last_phase, 1'b1);
        check_eq("single_posts", n_posts, 1);

        // phase wrap over 17 commands
        do_reset();
        p = n_posts;
        for (int i = 0; i < 17; i++) begin
            submit(16'($urandom_range(0, 65535)), (i % 4 == 2) ? 2'b10 : 2'b00);
            wait_done("wrap_done");
            db_write(12'd1012, {28'd0, m_cq_tail});
        end
        check_eq("wrap_posts", n_posts - p, 17);
        check_eq("wrap_addr", last_cq_addr, 32'h0002_0400);
        check_eq("wrap_phase", last_phase, 1'b0);

        // CQ full stall
        do_reset();
        for (int i = 0; i < 15; i++) begin
            submit(16'(i + 16'h100), 2'b00);
            wait_done("full_fill");
        end
        submit(16'h0ABC, 2'b00);
        saw_ar = 0;
        repeat (20) @(negedge clk);
        check_eq("cqfull_no_ar", saw_ar, 1'b0);
        db_write(12'd1012, 32'd1);
        wait_done("cqfull_resume");
        check_eq("cqfull_fetched", saw_ar, 1'b1);

        // write-data backpressure
        do_reset();
        w_delay = 3;
        bp_hits = 0;
        p = n_posts;
        submit(16'h5A5A, 2'b00);
        wait_done("bp_done");
        check_eq("bp_hits", bp_hits, 3);
        check_eq("bp_posts", n_posts - p, 1);
        w_delay = 0;

        // read error status and unmapped doorbell offset
        submit(16'hBEEF, 2'b10);
        wait_done("err_done");
        saw_ar = 0;
        db_write(12'h100, 32'h5);
        repeat (10) @(negedge clk);
        check_eq("decode_no_ar", saw_ar, 1'b0);
        submit(16'h1234, 2'b00);
        wait_done("decode_next");

        // reset while posting
        aw_delay = 1000;
        submit(16'h7777, 2'b00);
        n = 0;
        while (!cq_awvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_in_post", cq_awvalid, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("abort_valids",
                 {sq_arvalid, sq_rready, cq_awvalid, cq_wvalid, cq_bready, db_bvalid}, 6'b0);
        repeat (2) @(negedge clk);
        reset_model();
        aw_delay = 0;
        rst = 1'b0;
        p = n_posts;
        submit(16'h0042, 2'b00);
        wait_done("abort_restart");
        check_eq("abort_addr", last_cq_addr, 32'h0002_0400);
        check_eq("abort_phase", last_phase, 1'b1);
        check_eq("abort_posts", n_posts - p, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
